// File: rtl/pipe_stage.sv
// pipe_stage: elastic ready/valid pipeline stage with a two-entry skid buffer, flush and bubble masking.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage #(
    parameter int WIDTH          = 32,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             emit;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign emit      = main_valid & out_ready;
    assign occupancy = skid_valid ? TWO : main_valid ? ONE : EMPTY;
    assign out_data  = (ZERO_ON_BUBBLE && !main_valid) ? '0 : main_data;

    // Decide where an incoming or skidded entry goes this cycle; skid only fills when main stays blocked.
    always_comb begin
        load_main_in   = accept & (~main_valid | emit);
        load_main_skid = skid_valid & emit;
        load_skid      = accept & main_valid & ~emit;
    end

    // Valid bits: reset beats flush, flush empties both entries, skid refills main on emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= load_main_in | (main_valid & ~emit) | skid_valid;
            skid_valid <= load_skid | (skid_valid & ~emit);
        end
    end

    // Payload registers; a flush discards whatever would have been captured that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (!flush) begin
            if (load_main_in) main_data <= in_data;
            else if (load_main_skid) main_data <= skid_data;
            if (load_skid) skid_data <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating stall/bubble counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (!main_valid && !(&bubble_q)) bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed self-checking bench for pipe_stage in both bubble-masking modes.
module tb_pipe_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, in_ready_b, out_valid_b;
    logic [31:0] out_data, out_data_b;
    logic [1:0]  occupancy, occupancy_b;
    logic [3:0]  stall_cnt, bubble_cnt, stall_cnt_b, bubble_cnt_b;
    int          passed = 0;
    int          total = 0;

    pipe_stage #(.WIDTH(32), .ZERO_ON_BUBBLE(1'b1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage #(.WIDTH(32), .ZERO_ON_BUBBLE(1'b0), .CNT_W(4)) dut_stale (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occupancy_b), .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_data_stale", out_data_b, 32'd0);
        check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check("rst_bubble_cnt", {28'd0, bubble_cnt}, 32'd0);

        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", out_data, 32'hDEADBEEF);
        check("single_occ", {30'd0, occupancy}, 32'd1);
        tick();
        check("single_drain_valid", {31'd0, out_valid}, 32'd0);
        check("single_drain_zero", out_data, 32'd0);
        check("single_drain_stale", out_data_b, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            check("stream_data", out_data, i);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        in_valid = 1'b1; in_data = 32'hA;
        tick();
        check("skid_a_shown", out_data, 32'hA);
        out_ready = 1'b0; in_data = 32'hB;
        tick();
        check("skid_occ2", {30'd0, occupancy}, 32'd2);
        check("skid_in_ready0", {31'd0, in_ready}, 32'd0);
        check("skid_hold_a", out_data, 32'hA);
        in_data = 32'hC;
        tick();
        check("skid_c_held_occ", {30'd0, occupancy}, 32'd2);
        check("skid_c_held_data", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        check("skid_out_b", out_data, 32'hB);
        check("skid_occ1", {30'd0, occupancy}, 32'd1);
        check("skid_in_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("skid_out_c", out_data, 32'hC);
        tick();
        check("skid_empty_occ", {30'd0, occupancy}, 32'd0);
        check("skid_empty_valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        check("full_occ", {30'd0, occupancy}, 32'd2);
        flush = 1'b1; in_data = 32'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush_no_55", {31'd0, out_valid}, 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_empty_accept_dropped", {30'd0, occupancy}, 32'd0);
        tick();
        check("flush_empty_no_55", out_data_b === 32'h55 && out_valid_b ? 32'd1 : 32'd0, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
        tick();
        in_valid = 1'b0;
        check("collide_occ1", {30'd0, occupancy}, 32'd1);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        check("collide_occ", {30'd0, occupancy}, 32'd0);
        check("collide_valid", {31'd0, out_valid}, 32'd0);
        check("collide_stale_data", out_data_b, 32'd0);

        in_valid = 1'b1; in_data = 32'h1234;
        tick();
        in_valid = 1'b0;
        check("stale_live", out_data_b, 32'h1234);
        tick();
        check("stale_valid", {31'd0, out_valid_b}, 32'd0);
        check("stale_data", out_data_b, 32'h1234);
        check("masked_data", out_data, 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`ifdef PIPE_STAGE_PERF_EN
        check("bubble_count1", {28'd0, bubble_cnt}, 32'd1);
`else
        check("bubble_tied0", {28'd0, bubble_cnt}, 32'd0);
`endif
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
`ifdef PIPE_STAGE_PERF_EN
        check("stall_sat", {28'd0, stall_cnt}, 32'hF);
`else
        check("stall_tied0", {28'd0, stall_cnt}, 32'd0);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        check("stall_after_flush", {28'd0, stall_cnt}, 32'hF);
`else
        check("stall_after_flush_tied0", {28'd0, stall_cnt}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stall_after_rst", {28'd0, stall_cnt}, 32'd0);
        check("bubble_after_rst", {28'd0, bubble_cnt}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline stage with ready/valid handshake on both sides, a two-entry skid buffer, synchronous flush, and bubble masking of the output payload. Successor to the fixed-field stall-only inter-stage registers: replaces each stage boundary (fetch/decode, decode/execute, execute/memory, memory/writeback) with one instance whose payload is the concatenated control and data fields of that boundary. Upstream stalls come from deasserted `in_ready`, not a global pause wire. The hazard unit drives `flush` for branch and exception squash.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥ 1.
- `ZERO_ON_BUBBLE`, 1: when 1, `out_data` is forced to all-zero whenever `out_valid` = 0; when 0, `out_data` shows the stale main register.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all held entries; synchronous.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  payload to downstream.
- `occupancy`  out  2  number of held entries: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  cycles with `out_valid` = 1 and `out_ready` = 0.
- `bubble_cnt`  out  CNT_W  cycles with `out_valid` = 0.

## Operation
- Storage: main register (drives output) and skid register, each with a valid bit. State = occupancy: EMPTY (0), ONE (main only), TWO (main + skid). Skid is never valid while main is empty.
- Accept: `in_valid & in_ready`. Emit: `out_valid & out_ready`.
- `in_ready` = NOT skid_valid, taken directly from a register. It has no combinational path from `out_ready`.
- `out_valid` = main_valid. It is a register output.
- Transitions (no flush, no rst):
  - EMPTY: accept → ONE (main ← in); else stay.
  - ONE: accept & emit → ONE (main ← in); accept only → TWO (skid ← in); emit only → EMPTY; neither → hold.
  - TWO: emit → ONE (main ← skid, skid cleared); else hold. No accept is possible in TWO.
- Flush: next state EMPTY regardless of accept/emit. Any entry accepted in the flush cycle is discarded. An emit in the flush cycle is still a valid transfer downstream (the current `out_data` is legal that cycle).
- rst has priority over flush. In the rst cycle, all handshakes are ignored.
- `out_data` = main_data when main_valid; else 0 if `ZERO_ON_BUBBLE` = 1, else main_data.
- Ordering: strictly FIFO. Skid content always leaves after main content.

## Timing
- Latency: an entry accepted into EMPTY appears on `out_valid`/`out_data` the next cycle.
- Throughput: 1 entry/cycle while `out_ready` is held at 1.
- Backpressure: after `out_ready` drops, at most one more entry is accepted (into skid). `in_ready` falls in the cycle after skid fills. `in_ready` rises in the cycle after skid drains.
- Values after reset (first cycle after rst high):
  - `out_valid` = 0, `in_ready` = 1, `occupancy` = 0.
  - `out_data` = 0 (both modes; main_data resets to 0).
  - `stall_cnt` = 0, `bubble_cnt` = 0.
- Flush at cycle N: `out_valid` = 0, `occupancy` = 0 and `in_ready` = 1 from cycle N+1.
- Reset mid-transfer: any held entries are lost. No emit is produced in the rst cycle, even if `out_ready` = 1.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cnt` and `bubble_cnt` increment on their conditions each cycle rst is low.
  - Both saturate at all-ones.
  - Both are cleared only by rst, not by flush. The flush cycle itself is counted by its pre-flush state.
- Undefined: both counter ports are tied to constant 0 and no counter flops are instantiated.

## Test plan
- Reset then single transfer: rst 1 cycle; in_valid=1, in_data=0xDEADBEEF for 1 cycle, out_ready=1 → next cycle out_valid=1, out_data=0xDEADBEEF; following cycle out_valid=0, out_data=0.
- Streaming: 8 consecutive words 0..7, out_ready=1 throughout → out_data 0..7 on 8 consecutive cycles, in_ready never 0, occupancy ≤ 1.
- Backpressure/skid: stream 0xA,0xB,0xC with out_ready=0 from the cycle 0xA is shown → occupancy reaches 2, in_ready=0, 0xC held upstream; raise out_ready → outputs 0xA,0xB,0xC in order with no loss or duplication.
- Flush while full: occupancy=2, assert flush with in_valid=1, in_data=0x55 → next cycle occupancy=0, out_valid=0, in_ready=1; 0x55 never appears at the output.
- rst/flush collision and ZERO_ON_BUBBLE=0: hold occupancy 1 with 0x1234 and assert rst and flush together → state EMPTY; separately, with ZERO_ON_BUBBLE=0, drain 0x1234 → out_valid=0 while out_data still reads 0x1234.
- Counters (macro defined, CNT_W=4): out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 0xF; flush → stall_cnt remains 0xF; rst → 0.
